// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM initialisation sequencer:
// command encodings, mode-register field positions, the sequencer state
// enum and small elaboration-time helpers.
package sdram_pkg;

    // {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_AR  = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    // Mode-register field positions
    localparam int unsigned MR_BL_LSB  = 0;
    localparam int unsigned MR_CAS_LSB = 4;
    localparam int unsigned MR_WB_BIT  = 9;

    typedef enum logic [3:0] {
        S_WAIT,
        S_PRE,
        S_TRP,
        S_AR,
        S_TRFC,
        S_LMR,
        S_TMRD,
        S_EMR,
        S_TMRD2,
        S_DONE
    } state_t;

    function automatic logic [9:0] mode_word(input logic wb, input logic [2:0] cas,
                                             input logic [2:0] bl);
        logic [9:0] w;
        w                     = '0;
        w[MR_BL_LSB +: 3]     = bl;
        w[MR_CAS_LSB +: 3]    = cas;
        w[MR_WB_BIT]          = wb;
        return w;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sdram_gap_timer.sv
// Loadable saturating down-counter.
//   clk, rst : clock and synchronous active-high reset (reset loads RST_VAL)
//   load     : load counter with value
//   value    : load value
//   expired  : one-cycle pulse while the count is 1, i.e. the cycle before
//              the count reaches zero; an owner changing state on this
//              pulse does so exactly `value` edges after the load edge.
module sdram_gap_timer #(
    parameter int unsigned W       = 4,
    parameter int unsigned RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= W'(RST_VAL);
        end else if (load) begin
            r_cnt <= value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign expired = (r_cnt == W'(1));

endmodule

// File: rtl/sdram_init_cfg.sv
// SDRAM power-up initialisation sequencer.
// After reset: wait WAIT_CYC cycles, PRE-all, AREF_NUM auto-refreshes,
// LMR and optionally EMR, each followed by its NOP gap, then DONE.
// A reinit_req pulse in DONE restarts from PRE without the power-up wait.
//   clk, rst    : clock, synchronous active-high reset
//   reinit_req  : re-initialisation request pulse (honoured only in DONE)
//   init_cmd    : {CS_N,RAS_N,CAS_N,WE_N}
//   init_ba     : bank address
//   init_addr   : address bus
//   init_busy   : high while not DONE
//   init_end    : high in DONE
module sdram_init_cfg
    import sdram_pkg::*;
#(
    parameter int unsigned       WAIT_CYC   = 20000,
    parameter int unsigned       T_RP       = 2,
    parameter int unsigned       T_RFC      = 7,
    parameter int unsigned       T_MRD      = 3,
    parameter int unsigned       AREF_NUM   = 2,
    parameter int unsigned       ADDR_W     = 13,
    parameter int unsigned       BA_W       = 2,
    parameter int unsigned       CAS_LAT    = 3,
    parameter logic [2:0]        BURST_CODE = 3'b111,
    parameter bit                WB_SINGLE  = 1'b0,
    parameter bit                EMR_EN     = 1'b0,
    parameter logic [ADDR_W-1:0] EMR_VAL    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reinit_req,
    output logic [3:0]        init_cmd,
    output logic [BA_W-1:0]   init_ba,
    output logic [ADDR_W-1:0] init_addr,
    output logic              init_busy,
    output logic              init_end
);

    localparam int unsigned W_WAIT = $clog2(WAIT_CYC + 2);
    localparam int unsigned W_GAP  = $clog2(max3(T_RP, T_RFC, T_MRD) + 1) + 1;

    localparam logic [ADDR_W-1:0] LMR_ADDR = ADDR_W'(mode_word(WB_SINGLE, 3'(CAS_LAT), BURST_CODE));
    localparam logic [BA_W-1:0]   EMR_BA   = BA_W'(2'b10);
    localparam logic [3:0]        AREF_N   = 4'(AREF_NUM);

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_aref;
    logic              w_wait_exp;
    logic              w_gap_exp;
    logic              w_gap_load;
    logic [W_GAP-1:0]  w_gap_val;
    logic [3:0]        w_cmd;
    logic [BA_W-1:0]   w_ba;
    logic [ADDR_W-1:0] w_addr;

    // Reset preloads WAIT_CYC+1 so the WAIT->PRE edge lands on cycle WAIT_CYC.
    sdram_gap_timer #(
        .W       (W_WAIT),
        .RST_VAL (WAIT_CYC + 1)
    ) u_wait (
        .clk     (clk),
        .rst     (rst),
        .load    (1'b0),
        .value   ('0),
        .expired (w_wait_exp)
    );

    // Loaded on entry to each command state; the gap is counted from the
    // command cycle itself, so a gap of 1 skips the NOP hold state.
    sdram_gap_timer #(
        .W       (W_GAP),
        .RST_VAL (0)
    ) u_gap (
        .clk     (clk),
        .rst     (rst),
        .load    (w_gap_load),
        .value   (w_gap_val),
        .expired (w_gap_exp)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_WAIT:         if (w_wait_exp) w_state_next = S_PRE;
            S_PRE, S_TRP:   w_state_next = w_gap_exp ? S_AR : S_TRP;
            S_AR, S_TRFC: begin
                if (w_gap_exp) w_state_next = (r_aref < AREF_N) ? S_AR : S_LMR;
                else           w_state_next = S_TRFC;
            end
            S_LMR, S_TMRD: begin
                if (w_gap_exp) w_state_next = EMR_EN ? S_EMR : S_DONE;
                else           w_state_next = S_TMRD;
            end
            S_EMR, S_TMRD2: w_state_next = w_gap_exp ? S_DONE : S_TMRD2;
            S_DONE:         if (reinit_req) w_state_next = S_PRE;
            default:        w_state_next = S_WAIT;
        endcase
    end

    // Gap load and output decode follow the next state so every output
    // is registered yet aligned with the state it describes.
    always_comb begin
        w_gap_load = 1'b0;
        w_gap_val  = '0;
        w_cmd      = CMD_NOP;
        w_ba       = '1;
        w_addr     = '1;
        case (w_state_next)
            S_PRE: begin
                w_gap_load = 1'b1;
                w_gap_val  = W_GAP'(T_RP);
                w_cmd      = CMD_PRE;
            end
            S_AR: begin
                w_gap_load = 1'b1;
                w_gap_val  = W_GAP'(T_RFC);
                w_cmd      = CMD_AR;
            end
            S_LMR: begin
                w_gap_load = 1'b1;
                w_gap_val  = W_GAP'(T_MRD);
                w_cmd      = CMD_LMR;
                w_ba       = '0;
                w_addr     = LMR_ADDR;
            end
            S_EMR: begin
                w_gap_load = 1'b1;
                w_gap_val  = W_GAP'(T_MRD);
                w_cmd      = CMD_LMR;
                w_ba       = EMR_BA;
                w_addr     = EMR_VAL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_WAIT;
            r_aref    <= '0;
            init_cmd  <= CMD_NOP;
            init_ba   <= '1;
            init_addr <= '1;
            init_busy <= 1'b1;
            init_end  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == S_PRE) begin
                r_aref <= '0;
            end else if (w_state_next == S_AR) begin
                r_aref <= r_aref + 4'd1;
            end
            init_cmd  <= w_cmd;
            init_ba   <= w_ba;
            init_addr <= w_addr;
            init_busy <= (w_state_next != S_DONE);
            init_end  <= (w_state_next == S_DONE);
        end
    end

endmodule

// File: tb/tb_sdram_init_cfg.sv
// Self-checking bench for sdram_init_cfg: four differently configured
// instances, each compared cycle by cycle against a schedule computed
// from the command spacing rules.
module tb_sdram_init_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  rst = '1;
    logic [3:0]  rq  = '0;
    logic [3:0]  o_cmd  [4];
    logic [1:0]  o_ba   [4];
    logic [12:0] o_addr [4];
    logic        o_end  [4];
    logic        o_busy [4];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          wait_c;
        int          trp;
        int          trfc;
        int          tmrd;
        int          aref;
        bit          emr_en;
        logic [12:0] emr_val;
        logic [12:0] lmr;
    } cfg_t;

    cfg_t cfgs [4];

    localparam logic [20:0] RST_EXP = {4'b0111, 2'b11, 13'h1fff, 1'b0, 1'b1};

    sdram_init_cfg #(.WAIT_CYC(20)) d0 (
        .clk(clk), .rst(rst[0]), .reinit_req(rq[0]), .init_cmd(o_cmd[0]), .init_ba(o_ba[0]),
        .init_addr(o_addr[0]), .init_busy(o_busy[0]), .init_end(o_end[0]));

    sdram_init_cfg #(.WAIT_CYC(10), .AREF_NUM(4), .T_RFC(5)) d1 (
        .clk(clk), .rst(rst[1]), .reinit_req(rq[1]), .init_cmd(o_cmd[1]), .init_ba(o_ba[1]),
        .init_addr(o_addr[1]), .init_busy(o_busy[1]), .init_end(o_end[1]));

    sdram_init_cfg #(.WAIT_CYC(12), .EMR_EN(1'b1), .EMR_VAL(13'h0020)) d2 (
        .clk(clk), .rst(rst[2]), .reinit_req(rq[2]), .init_cmd(o_cmd[2]), .init_ba(o_ba[2]),
        .init_addr(o_addr[2]), .init_busy(o_busy[2]), .init_end(o_end[2]));

    sdram_init_cfg #(.WAIT_CYC(5), .T_RP(1), .T_RFC(1), .T_MRD(1), .AREF_NUM(1),
                     .CAS_LAT(2), .BURST_CODE(3'b011), .WB_SINGLE(1'b1)) d3 (
        .clk(clk), .rst(rst[3]), .reinit_req(rq[3]), .init_cmd(o_cmd[3]), .init_ba(o_ba[3]),
        .init_addr(o_addr[3]), .init_busy(o_busy[3]), .init_end(o_end[3]));

    function automatic cfg_t mk_cfg(input int w, input int trp, input int trfc, input int tmrd,
                                    input int aref, input bit emr_en, input logic [12:0] emr_val,
                                    input int wb, input int cas, input int bl);
        cfg_t c;
        c.wait_c  = w;
        c.trp     = trp;
        c.trfc    = trfc;
        c.tmrd    = tmrd;
        c.aref    = aref;
        c.emr_en  = emr_en;
        c.emr_val = emr_val;
        c.lmr     = 13'(wb * 512 + cas * 16 + bl);
        return c;
    endfunction

    function automatic int done_cyc(input cfg_t c, input int pre);
        int lmr;
        lmr = pre + c.trp + c.aref * c.trfc;
        return c.emr_en ? lmr + 2 * c.tmrd : lmr + c.tmrd;
    endfunction

    // Expected {cmd, ba, addr, end, busy} on cycle k when PRE is on cycle pre.
    function automatic logic [20:0] exp_vec(input cfg_t c, input int k, input int pre);
        int          ar0;
        int          lmr;
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] a;
        ar0 = pre + c.trp;
        lmr = ar0 + c.aref * c.trfc;
        cmd = 4'b0111;
        ba  = 2'b11;
        a   = 13'h1fff;
        if (k >= done_cyc(c, pre)) return {cmd, ba, a, 1'b1, 1'b0};
        if (k == pre) begin
            cmd = 4'b0010;
        end else if (k >= ar0 && k < lmr && ((k - ar0) % c.trfc) == 0) begin
            cmd = 4'b0001;
        end else if (k == lmr) begin
            cmd = 4'b0000; ba = 2'b00; a = c.lmr;
        end else if (c.emr_en && k == lmr + c.tmrd) begin
            cmd = 4'b0000; ba = 2'b10; a = c.emr_val;
        end
        return {cmd, ba, a, 1'b0, 1'b1};
    endfunction

    function automatic logic [20:0] obs(input int i);
        return {o_cmd[i], o_ba[i], o_addr[i], o_end[i], o_busy[i]};
    endfunction

    task automatic test_reset(input int i);
        int n;
        rst[i] = 1'b1;
        n = $urandom_range(2, 5);
        for (int j = 0; j < n; j++) begin
            @(posedge clk); #1;
            checks++;
            if (obs(i) !== RST_EXP) begin
                errors++;
                $display("FAIL reset[%0d] cyc=%0d got=%h want=%h", i, j, obs(i), RST_EXP);
            end
        end
    endtask

    // Release reset and follow the power-up sequence; optionally throw in a
    // reinit pulse while busy, which must change nothing.
    task automatic test_power_up(input int i, input bit noise);
        cfg_t c;
        int   dn;
        int   pk;
        c  = cfgs[i];
        dn = done_cyc(c, c.wait_c);
        pk = noise ? int'($urandom_range(0, dn - 2)) : -1;
        @(negedge clk);
        rst[i] = 1'b0;
        for (int k = 0; k <= dn + 2; k++) begin
            @(posedge clk); #1;
            rq[i] = (k == pk);
            checks++;
            if (obs(i) !== exp_vec(c, k, c.wait_c)) begin
                errors++;
                $display("FAIL power_up[%0d] k=%0d got=%h want=%h", i, k, obs(i), exp_vec(c, k, c.wait_c));
            end
        end
        rq[i] = 1'b0;
    endtask

    task automatic test_reinit(input int i);
        cfg_t c;
        int   n;
        int   dn;
        c  = cfgs[i];
        dn = done_cyc(c, 0);
        n  = $urandom_range(0, 6);
        for (int j = 0; j < n; j++) begin
            @(posedge clk); #1;
            checks++;
            if (obs(i) !== exp_vec(c, 1000, 0)) begin
                errors++;
                $display("FAIL done_hold[%0d] cyc=%0d got=%h want=%h", i, j, obs(i), exp_vec(c, 1000, 0));
            end
        end
        rq[i] = 1'b1;
        for (int k = 0; k <= dn + 2; k++) begin
            @(posedge clk); #1;
            rq[i] = 1'b0;
            checks++;
            if (obs(i) !== exp_vec(c, k, 0)) begin
                errors++;
                $display("FAIL reinit[%0d] k=%0d got=%h want=%h", i, k, obs(i), exp_vec(c, k, 0));
            end
        end
    endtask

    // Second reinit arrives on the very first DONE cycle.
    task automatic test_back_to_back(input int i);
        cfg_t        c;
        int          dn;
        logic [20:0] e;
        c  = cfgs[i];
        dn = done_cyc(c, 0);
        rq[i] = 1'b1;
        for (int k = 0; k <= 2 * dn + 3; k++) begin
            @(posedge clk); #1;
            rq[i] = (k == dn);
            e = (k <= dn) ? exp_vec(c, k, 0) : exp_vec(c, k - dn - 1, 0);
            checks++;
            if (obs(i) !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d] k=%0d got=%h want=%h", i, k, obs(i), e);
            end
        end
        rq[i] = 1'b0;
    endtask

    // Reset asserted on the second AR cycle; full wait must repeat.
    task automatic test_reset_mid(input int i);
        cfg_t c;
        int   ar2;
        int   dn;
        c   = cfgs[i];
        ar2 = c.wait_c + c.trp + c.trfc;
        dn  = done_cyc(c, c.wait_c);
        test_reset(i);
        @(negedge clk);
        rst[i] = 1'b0;
        for (int k = 0; k <= ar2; k++) begin
            @(posedge clk); #1;
            checks++;
            if (obs(i) !== exp_vec(c, k, c.wait_c)) begin
                errors++;
                $display("FAIL pre_rst[%0d] k=%0d got=%h want=%h", i, k, obs(i), exp_vec(c, k, c.wait_c));
            end
        end
        test_reset(i);
        @(negedge clk);
        rst[i] = 1'b0;
        for (int k = 0; k <= dn + 1; k++) begin
            @(posedge clk); #1;
            checks++;
            if (obs(i) !== exp_vec(c, k, c.wait_c)) begin
                errors++;
                $display("FAIL post_rst[%0d] k=%0d got=%h want=%h", i, k, obs(i), exp_vec(c, k, c.wait_c));
            end
        end
    endtask

    initial begin
        cfgs[0] = mk_cfg(20, 2, 7, 3, 2, 1'b0, 13'h0000, 0, 3, 7);
        cfgs[1] = mk_cfg(10, 2, 5, 3, 4, 1'b0, 13'h0000, 0, 3, 7);
        cfgs[2] = mk_cfg(12, 2, 7, 3, 2, 1'b1, 13'h0020, 0, 3, 7);
        cfgs[3] = mk_cfg(5, 1, 1, 1, 1, 1'b0, 13'h0000, 1, 2, 3);

        test_reset(0);
        test_power_up(0, 1'b0);
        test_reinit(0);
        test_reset_mid(0);
        test_reset(1);
        test_power_up(1, 1'b1);
        test_reinit(1);
        test_reset(2);
        test_power_up(2, 1'b1);
        test_reinit(2);
        test_back_to_back(2);
        test_reset(3);
        test_power_up(3, 1'b1);
        test_reinit(3);
        test_back_to_back(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_init_cfg.md
# sdram_init_cfg

Parametrised SDRAM power-up initialisation sequencer: second generation of the team's fixed-timing init block. After reset it waits a configurable power-up time, then issues precharge-all, N auto-refreshes, load-mode-register and an optional extended-mode-register command, each separated by its own parametrised NOP gap. It also supports a host-requested re-initialisation without the power-up wait. It sits between the SDRAM top arbiter and the command mux, and drives the command/bank/address bus until `init_end` is asserted.

## Interface
- `WAIT_CYC`, 20000: power-up wait in clk cycles (200 µs at 100 MHz); ≥ 2.
- `T_RP`, 2: cycles from a PRE command to the next command; ≥ 1.
- `T_RFC`, 7: cycles from an AR command to the next command; ≥ 1.
- `T_MRD`, 3: cycles from an LMR/EMR command to the next command or to `init_end`; ≥ 1.
- `AREF_NUM`, 2: number of auto-refresh commands; 1..15.
- `ADDR_W`, 13: address bus width; ≥ 11.
- `BA_W`, 2: bank address width.
- `CAS_LAT`, 3: CAS latency code, mode register bits [6:4].
- `BURST_CODE`, 3'b111: burst length code, bits [2:0] (full page).
- `WB_SINGLE`, 0: write-burst mode, bit 9.
- `EMR_EN`, 0: issue the extended mode register command after LMR.
- `EMR_VAL`, 0: EMR address value. The EMR command uses bank `BA_W'b10`.
- `clk`  in  1  system clock. One clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `reinit_req`  in  1  single-cycle pulse requesting re-initialisation; honoured only in DONE.
- `init_cmd`  out  4  {CS_N,RAS_N,CAS_N,WE_N}.
- `init_ba`  out  BA_W  bank address.
- `init_addr`  out  ADDR_W  address bus.
- `init_busy`  out  1  high whenever the state is not DONE.
- `init_end`  out  1  high in DONE; sequence complete.

## Operation
- Command encodings:
  - NOP 4'b0111
  - PRE 4'b0010
  - AR 4'b0001
  - LMR/EMR 4'b0000
- States: WAIT → PRE → TRP → AR → TRFC → (AR, or LMR) → TMRD → (EMR → TMRD2 →) DONE.
- WAIT counts `WAIT_CYC` cycles, then moves to PRE. It is entered only from reset.
- PRE, AR, LMR and EMR each last exactly one cycle and drive their command. Every other state drives NOP.
- TRP, TRFC, TMRD and TMRD2 hold NOP until the gap counter expires.
- The refresh counter increments on each AR command.
- From TRFC:
  - Return to AR while count < `AREF_NUM`.
  - Otherwise go to LMR.
- From TMRD: go to EMR if `EMR_EN`, else to DONE.
- DONE is held indefinitely.
- When `reinit_req` is seen in DONE, go directly to PRE and clear the refresh counter.
- `reinit_req` in any other state is ignored; it is not queued.
- Address and bank values:
  - PRE: addr all ones (A10 = 1, precharge all).
  - LMR: addr = {0…, WB_SINGLE, 2'b00, CAS_LAT[2:0], 1'b0, BURST_CODE}; defaults give 13'h0037. Bank = 0.
  - EMR: addr = `EMR_VAL`, bank = `BA_W'b10`.
  - All other states: addr all ones, bank all ones.

## Timing
- All outputs are registered.
- Reset values:
  - `init_cmd` = NOP
  - `init_ba` = all ones
  - `init_addr` = all ones
  - `init_end` = 0
  - `init_busy` = 1
- Cycle 0 is the first clock edge with `rst` low. The PRE command appears at cycle `WAIT_CYC`.
- Command spacing (next command cycle relative to the issuing command cycle):
  - After PRE: next AR at c + `T_RP`.
  - After each AR: next command at c + `T_RFC`.
  - After LMR: EMR at c + `T_MRD` if enabled, else `init_end` rises at c + `T_MRD`.
  - After EMR: `init_end` rises at c + `T_MRD`.
- Re-init: a pulse at cycle r in DONE gives:
  - `init_end` = 0 and `init_busy` = 1 at r+1.
  - PRE command at r+1.
- `rst` asserted mid-sequence: next cycle all outputs return to reset values, state = WAIT, counters = 0, and the full power-up wait repeats.
- Gap counter width is $clog2 of max(`T_RP`, `T_RFC`, `T_MRD`) + 1. The wait counter is sized from `WAIT_CYC`. No counter wraps; each saturates or reloads.

## Structure
- Shared package `sdram_pkg`:
  - command encodings
  - mode-register field positions
  - state enum
- One sub-module, `sdram_gap_timer`: loadable down-counter with `load`, `value` and an `expired` pulse. It is used for the WAIT count and for all T_* gaps.

## Test plan
- Defaults with `WAIT_CYC`=20 → PRE at cycle 20, AR at 22 and 29, LMR at 36 with addr 13'h0037 and ba 0, `init_end` at 39.
- `AREF_NUM`=4, `T_RFC`=5 → exactly 4 AR commands spaced 5 cycles apart, then LMR.
- `EMR_EN`=1, `EMR_VAL`=13'h0020 → EMR with ba 2'b10 and addr 13'h0020 at LMR+3; `init_end` at EMR+3.
- `reinit_req` pulse in DONE → `init_end` drops next cycle, PRE issued without the wait, full sequence completes again. A pulse mid-sequence has no effect.
- `rst` asserted at the second AR → outputs return to reset values; PRE reappears `WAIT_CYC` cycles after release.
- `CAS_LAT`=2, `BURST_CODE`=3'b011, `WB_SINGLE`=1 → LMR addr 13'h0223.
